// File: rtl/fetch_queue_unit.sv
// Instruction fetch front end: PC, direct-mapped i-cache, 2-bit BHT predictor and a
// small circular instruction queue that decouples fetch from issue.
module fetch_queue_unit #(
  parameter int         ICACHE_IDX_W = 8,
  parameter int         BHT_IDX_W    = 8,
  parameter int         IQ_DEPTH_W   = 2,
  parameter logic [1:0] BHT_INIT     = 2'b10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mc_ready_in,
  input  logic [31:0]           mc_instruction_in,
  output logic                  mc_request_out,
  output logic [31:0]           mc_address_out,
  input  logic                  stall_in,
  input  logic                  rob_rollback_in,
  input  logic [31:0]           rob_rollback_pc_in,
  input  logic                  rob_commit_signal_in,
  input  logic [31:0]           rob_commit_pc_in,
  input  logic                  rob_branch_taken_in,
  output logic                  dec_issue_out,
  output logic [31:0]           dec_inst_out,
  output logic [31:0]           dec_pc_out,
  output logic [31:0]           dec_predict_pc_out,
  output logic [IQ_DEPTH_W:0]   iq_count_out
);

  localparam int IC_LINES = 1 << ICACHE_IDX_W;
  localparam int TAG_W    = 32 - ICACHE_IDX_W - 2;
  localparam int BHT_N    = 1 << BHT_IDX_W;
  localparam int DEPTH    = 1 << IQ_DEPTH_W;
  localparam logic [IQ_DEPTH_W:0] IQ_FULL   = (IQ_DEPTH_W + 1)'(DEPTH);
  localparam logic [6:0]          OP_JAL    = 7'b1101111;
  localparam logic [6:0]          OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {S_IDLE, S_WAITING, S_DISCARD} state_t;

  state_t                  state_q, state_d;
  logic [31:0]             pc_q, pc_d;
  logic [IQ_DEPTH_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [IQ_DEPTH_W:0]     count_q, count_d;
  logic                    mc_request_q, mc_request_d;
  logic [31:0]             mc_address_q, mc_address_d;
  logic                    dec_issue_q, dec_issue_d;
  logic [31:0]             dec_inst_q, dec_inst_d;
  logic [31:0]             dec_pc_q, dec_pc_d;
  logic [31:0]             dec_npc_q, dec_npc_d;

  logic                    ic_valid_q [IC_LINES];
  logic [TAG_W-1:0]        ic_tag_q   [IC_LINES];
  logic [31:0]             ic_data_q  [IC_LINES];
  logic [1:0]              bht_q      [BHT_N];
  logic [31:0]             iq_inst_q  [DEPTH];
  logic [31:0]             iq_pc_q    [DEPTH];
  logic [31:0]             iq_npc_q   [DEPTH];

  logic [ICACHE_IDX_W-1:0] ic_idx;
  logic [BHT_IDX_W-1:0]    bht_rd_idx, bht_wr_idx;
  logic                    hit, can_fetch, enq, miss, deq, fill;
  logic [31:0]             hit_inst, imm_j, imm_b, npc;
  logic [1:0]              bht_cur, bht_next;

  // Cache lookup, next-PC prediction and the push/pop/fill qualifiers for this cycle
  always_comb begin
    ic_idx     = pc_q[ICACHE_IDX_W+1:2];
    bht_rd_idx = pc_q[BHT_IDX_W+1:2];
    hit        = ic_valid_q[ic_idx] && (ic_tag_q[ic_idx] == pc_q[31:ICACHE_IDX_W+2]);
    hit_inst   = ic_data_q[ic_idx];
    imm_j      = {{12{hit_inst[31]}}, hit_inst[19:12], hit_inst[20], hit_inst[30:21], 1'b0};
    imm_b      = {{20{hit_inst[31]}}, hit_inst[7], hit_inst[30:25], hit_inst[11:8], 1'b0};
    npc        = pc_q + 32'd4;
    if (hit_inst[6:0] == OP_JAL) begin
      npc = pc_q + imm_j;
    end else if (hit_inst[6:0] == OP_BRANCH && bht_q[bht_rd_idx][1]) begin
      npc = pc_q + imm_b;
    end
    // A rollback cycle neither fetches nor issues; the new PC takes effect next cycle.
    can_fetch = (state_q == S_IDLE) && (count_q < IQ_FULL) && !rob_rollback_in;
    enq       = can_fetch && hit;
    miss      = can_fetch && !hit;
    deq       = (count_q != '0) && !stall_in && !rob_rollback_in;
    fill      = (state_q == S_WAITING) && mc_ready_in;
  end

  // Saturating 2-bit counter update for the committed branch
  always_comb begin
    bht_wr_idx = rob_commit_pc_in[BHT_IDX_W+1:2];
    bht_cur    = bht_q[bht_wr_idx];
    bht_next   = bht_cur;
    if (rob_branch_taken_in) begin
      if (bht_cur != 2'b11) bht_next = bht_cur + 2'd1;
    end else begin
      if (bht_cur != 2'b00) bht_next = bht_cur - 2'd1;
    end
  end

  // Next-state logic for the fetch FSM, PC, queue pointers and registered outputs
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    mc_request_d = 1'b0;
    mc_address_d = mc_address_q;
    dec_issue_d  = 1'b0;
    dec_inst_d   = dec_inst_q;
    dec_pc_d     = dec_pc_q;
    dec_npc_d    = dec_npc_q;

    case (state_q)
      S_IDLE: begin
        if (miss) begin
          mc_request_d = 1'b1;
          mc_address_d = pc_q;
          state_d      = S_WAITING;
        end
      end
      S_WAITING: begin
        if (mc_ready_in)          state_d = S_IDLE;
        else if (rob_rollback_in) state_d = S_DISCARD;
      end
      S_DISCARD: begin
        if (mc_ready_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (enq) begin
      tail_d = tail_q + 1'b1;
      pc_d   = npc;
    end
    if (deq) begin
      head_d      = head_q + 1'b1;
      dec_issue_d = 1'b1;
      dec_inst_d  = iq_inst_q[head_q];
      dec_pc_d    = iq_pc_q[head_q];
      dec_npc_d   = iq_npc_q[head_q];
    end
    if (enq && !deq)      count_d = count_q + 1'b1;
    else if (!enq && deq) count_d = count_q - 1'b1;

    if (rob_rollback_in) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      pc_d    = rob_rollback_pc_in;
    end
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      mc_request_q <= 1'b0;
      mc_address_q <= '0;
      dec_issue_q  <= 1'b0;
      dec_inst_q   <= '0;
      dec_pc_q     <= '0;
      dec_npc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      mc_request_q <= mc_request_d;
      mc_address_q <= mc_address_d;
      dec_issue_q  <= dec_issue_d;
      dec_inst_q   <= dec_inst_d;
      dec_pc_q     <= dec_pc_d;
      dec_npc_q    <= dec_npc_d;
    end
  end

  // Queue storage written at the tail; contents need no reset because count gates reads
  always_ff @(posedge clk) begin
    if (enq) begin
      iq_inst_q[tail_q] <= hit_inst;
      iq_pc_q[tail_q]   <= pc_q;
      iq_npc_q[tail_q]  <= npc;
    end
  end

  // I-cache: valid bits cleared on reset only, line filled from the outstanding miss address
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < IC_LINES; i++) ic_valid_q[i] <= 1'b0;
    end else if (fill) begin
      ic_valid_q[ic_idx] <= 1'b1;
      ic_tag_q[ic_idx]   <= pc_q[31:ICACHE_IDX_W+2];
      ic_data_q[ic_idx]  <= mc_instruction_in;
    end
  end

  // BHT training; lookups this cycle see the value before the update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= BHT_INIT;
    end else if (rob_commit_signal_in) begin
      bht_q[bht_wr_idx] <= bht_next;
    end
  end

  assign mc_request_out     = mc_request_q;
  assign mc_address_out     = mc_address_q;
  assign dec_issue_out      = dec_issue_q;
  assign dec_inst_out       = dec_inst_q;
  assign dec_pc_out         = dec_pc_q;
  assign dec_predict_pc_out = dec_npc_q;
  assign iq_count_out       = count_q;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit: a program-level reference model generates the
// expected issue stream; a memory-controller model serves fetches with random latency.
module tb_fetch_queue_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mc_ready_in;
  logic [31:0] mc_instruction_in;
  logic        mc_request_out;
  logic [31:0] mc_address_out;
  logic        stall_in;
  logic        rob_rollback_in;
  logic [31:0] rob_rollback_pc_in;
  logic        rob_commit_signal_in;
  logic [31:0] rob_commit_pc_in;
  logic        rob_branch_taken_in;
  logic        dec_issue_out;
  logic [31:0] dec_inst_out;
  logic [31:0] dec_pc_out;
  logic [31:0] dec_predict_pc_out;
  logic [2:0]  iq_count_out;

  fetch_queue_unit dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .mc_ready_in         (mc_ready_in),
    .mc_instruction_in   (mc_instruction_in),
    .mc_request_out      (mc_request_out),
    .mc_address_out      (mc_address_out),
    .stall_in            (stall_in),
    .rob_rollback_in     (rob_rollback_in),
    .rob_rollback_pc_in  (rob_rollback_pc_in),
    .rob_commit_signal_in(rob_commit_signal_in),
    .rob_commit_pc_in    (rob_commit_pc_in),
    .rob_branch_taken_in (rob_branch_taken_in),
    .dec_issue_out       (dec_issue_out),
    .dec_inst_out        (dec_inst_out),
    .dec_pc_out          (dec_pc_out),
    .dec_predict_pc_out  (dec_predict_pc_out),
    .iq_count_out        (iq_count_out)
  );

  always #5 clk = ~clk;

  localparam int K_ALU = 0, K_JAL = 1, K_BR = 2, K_JALR = 3;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_word [1024];
  int          mem_kind [1024];
  int          mem_off  [1024];
  int          bht_m    [256];
  int          n_checks = 0;
  int          n_errors = 0;
  int          mc_lat = 0;
  int          mc_cd = 0;
  logic [31:0] mc_addr = '0;
  bit          stale_inject = 0;
  bit          req_prev = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_j(input int off);
    logic [31:0] o;
    o = off;
    return {o[20], o[10:1], o[11], o[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_b(input int off);
    logic [31:0] o;
    o = off;
    return {o[12], o[10:5], 5'd2, 5'd1, 3'b000, o[4:1], o[11], 7'b1100011};
  endfunction

  // Reference program flow: each instruction's successor follows from its kind and offset.
  function automatic logic [31:0] model_npc(input logic [31:0] p);
    int i;
    i = int'(p[11:2]);
    case (mem_kind[i])
      K_JAL:   return p + mem_off[i];
      K_BR:    return (bht_m[p[9:2]] >= 2) ? p + mem_off[i] : p + 32'd4;
      default: return p + 32'd4;
    endcase
  endfunction

  task automatic regen(input logic [31:0] start);
    logic [31:0] p;
    exp_t e;
    exp_q.delete();
    p = start;
    for (int k = 0; k < 200; k++) begin
      e.inst = mem_word[p[11:2]];
      e.pc   = p;
      e.npc  = model_npc(p);
      exp_q.push_back(e);
      p = e.npc;
    end
  endtask

  task automatic train(input logic [31:0] p, input bit taken);
    int i;
    i = int'(p[9:2]);
    if (taken && bht_m[i] < 3) bht_m[i]++;
    else if (!taken && bht_m[i] > 0) bht_m[i]--;
  endtask

  // Memory controller: one outstanding fetch, answered after mc_lat (or random) cycles
  initial begin
    mc_ready_in = 1'b0;
    mc_instruction_in = '0;
    forever begin
      @(posedge clk);
      #2;
      mc_ready_in = 1'b0;
      if (stale_inject) begin
        mc_ready_in = 1'b1;
        mc_instruction_in = 32'hDEADBEEF;
        stale_inject = 0;
      end else if (!rst_n) begin
        mc_cd = 0;
      end else begin
        if (mc_cd > 0) begin
          mc_cd--;
          if (mc_cd == 0) begin
            mc_ready_in = 1'b1;
            mc_instruction_in = mem_word[mc_addr[11:2]];
          end
        end
        if (mc_request_out) begin
          mc_addr = mc_address_out;
          mc_cd = (mc_lat != 0) ? mc_lat : int'($urandom_range(1, 4));
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every issue pulse
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("iq_count_bound", 32'(iq_count_out > 3'd4), 32'd0);
      if (mc_request_out && req_prev) chk("mc_request_pulse", 32'd2, 32'd1);
      req_prev = mc_request_out;
      if (dec_issue_out) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL issue_unexpected: got pc 0x%08h expected no issue", dec_pc_out);
        end else begin
          e = exp_q.pop_front();
          chk("issue_inst", dec_inst_out, e.inst);
          chk("issue_pc", dec_pc_out, e.pc);
          chk("issue_predict", dec_predict_pc_out, e.npc);
        end
      end
    end else begin
      req_prev = 0;
    end
  end

  task automatic check_reset_outputs();
    chk("rst_mc_request", 32'(mc_request_out), 32'd0);
    chk("rst_mc_address", mc_address_out, 32'd0);
    chk("rst_dec_issue", 32'(dec_issue_out), 32'd0);
    chk("rst_dec_inst", dec_inst_out, 32'd0);
    chk("rst_dec_pc", dec_pc_out, 32'd0);
    chk("rst_dec_predict", dec_predict_pc_out, 32'd0);
    chk("rst_iq_count", 32'(iq_count_out), 32'd0);
  endtask

  task automatic wait_req(input string name, input logic [31:0] exp_addr, input int budget);
    bit seen;
    seen = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (mc_request_out) begin
        seen = 1;
        chk(name, mc_address_out, exp_addr);
      end
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got no request within %0d cycles expected addr 0x%08h", name, budget, exp_addr);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
    stale_inject = 1;
    for (int i = 0; i < 256; i++) bht_m[i] = 2;
    regen(32'h0);
  endtask

  task automatic rollback(input logic [31:0] target, input bit stall, input bit commit,
                          input logic [31:0] cpc, input bit taken);
    @(posedge clk);
    #1;
    rob_rollback_in = 1'b1;
    rob_rollback_pc_in = target;
    stall_in = stall;
    rob_commit_signal_in = commit;
    rob_commit_pc_in = cpc;
    rob_branch_taken_in = taken;
    if (commit) train(cpc, taken);
    @(posedge clk);
    #1;
    rob_rollback_in = 1'b0;
    rob_commit_signal_in = 1'b0;
    regen(target);
    @(negedge clk);
    chk("rb_issue_low", 32'(dec_issue_out), 32'd0);
    chk("rb_iq_empty", 32'(iq_count_out), 32'd0);
  endtask

  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      stall_in = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic segment(input bit do_stall);
    logic [31:0] rb;
    logic [31:0] cpc;
    bit taken;
    rb = {$urandom_range(0, 1) == 1 ? 16'h0001 : 16'h0000, 4'h0, 10'($urandom_range(0, 1023)), 2'b00};
    if (do_stall) begin
      for (int c = 0; c < 40; c++) begin
        @(posedge clk);
        #1;
        stall_in = 1'b1;
        rob_commit_signal_in = ($urandom_range(0, 1) == 1);
        rob_commit_pc_in = rb + 32'(4 * $urandom_range(0, 15));
        rob_branch_taken_in = ($urandom_range(0, 1) == 1);
        if (rob_commit_signal_in) train(rob_commit_pc_in, rob_branch_taken_in);
      end
      @(negedge clk);
      chk("iq_count_full", 32'(iq_count_out), 32'd4);
    end
    cpc = rb + 32'(4 * $urandom_range(0, 15));
    taken = ($urandom_range(0, 1) == 1);
    rollback(rb, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, cpc, taken);
    run(120);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    for (int i = 0; i < 1024; i++) begin
      r = int'($urandom_range(0, 99));
      mem_off[i] = 4 * int'($urandom_range(0, 32)) - 64;
      if (r < 50) begin
        mem_kind[i] = K_ALU;
        mem_word[i] = {12'($urandom), 5'($urandom), 3'b000, 5'($urandom), 7'b0010011};
      end else if (r < 65) begin
        mem_kind[i] = K_JAL;
        mem_word[i] = enc_j(mem_off[i]);
      end else if (r < 85) begin
        mem_kind[i] = K_BR;
        mem_word[i] = enc_b(mem_off[i]);
      end else begin
        mem_kind[i] = K_JALR;
        mem_word[i] = 32'h00008067;
      end
    end
    mem_kind[0] = K_ALU;
    mem_word[0] = 32'h00000013;
    mem_kind[8] = K_BR;
    mem_off[8] = 8;
    mem_word[8] = enc_b(8);

    rst_n = 1'b0;
    stall_in = 1'b0;
    rob_rollback_in = 1'b0;
    rob_rollback_pc_in = '0;
    rob_commit_signal_in = 1'b0;
    rob_commit_pc_in = '0;
    rob_branch_taken_in = 1'b0;

    // Power-on reset, then a miss at 0 that is abandoned by a rollback while waiting.
    mc_lat = 6;
    do_reset(3);
    wait_req("first_req_addr", 32'h0, 20);
    rollback(32'h200, 1'b0, 1'b0, 32'h0, 1'b0);
    wait_req("after_discard_addr", 32'h200, 40);
    run(60);
    rollback(32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    wait_req("discarded_not_cached", 32'h0, 40);
    run(60);

    // Branch at 0x20: predicted taken, then trained toward not-taken.
    mc_lat = 0;
    rollback(32'h20, 1'b0, 1'b1, 32'h20, 1'b0);
    run(40);
    rollback(32'h20, 1'b0, 1'b1, 32'h20, 1'b0);
    run(40);

    for (int s = 0; s < 12; s++) segment(s % 2 == 0);

    // Reset in the middle of an outstanding miss.
    begin
      bit busy;
      busy = 0;
      for (int c = 0; c < 60 && !busy; c++) begin
        @(negedge clk);
        busy = (mc_cd > 1);
      end
      if (!busy) begin
        n_checks++;
        n_errors++;
        $display("FAIL midmiss_wait: got no outstanding miss expected one");
      end
    end
    do_reset(2);
    wait_req("post_reset_req_addr", 32'h0, 20);
    run(100);
    segment(1'b1);

    stall_in = 1'b0;
    repeat (20) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
